// File: rtl/cdb_arbiter_pkg.sv
// Small helpers shared by the CDB arbiter and its round-robin picker.
package cdb_arbiter_pkg;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int wrap_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sys_defs_pkg.sv
// Shared machine-wide widths and the CDB broadcast record used by the ROB,
// the reservation stations and the CDB arbiter.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH
`define XLEN        32
`define ROB_TAG_LEN 5
`endif

package sys_defs;

  typedef struct packed {
    logic                    valid;
    logic [`ROB_TAG_LEN-1:0] rob_tag;
    logic [`XLEN-1:0]        value;
  } CDB_DATA;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester at or after ptr wins.
module rr_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any_grant
);

  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any_grant && req[j]) begin
        any_grant = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = PW'(j);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Buffers one result per functional unit and broadcasts at most one buffered
// result per cycle on the registered common data bus, in round-robin order.
module cdb_arbiter
  import sys_defs::*;
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = 4
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic [NUM_FU-1:0]                    fu_valid,
  input  logic [NUM_FU-1:0][`ROB_TAG_LEN-1:0]  fu_rob_tag,
  input  logic [NUM_FU-1:0][`XLEN-1:0]         fu_value,
  output logic [NUM_FU-1:0]                    fu_ready,
  output CDB_DATA                              cdb_data,
  output logic [$clog2(NUM_FU+1)-1:0]          buf_occupancy
);

  localparam int PW = ptr_width(NUM_FU);
  localparam int OW = $clog2(NUM_FU + 1);

  logic [NUM_FU-1:0]                   buf_valid;
  logic [NUM_FU-1:0][`ROB_TAG_LEN-1:0] buf_tag;
  logic [NUM_FU-1:0][`XLEN-1:0]        buf_value;
  logic [PW-1:0]                       rr_ptr;

  logic [NUM_FU-1:0] grant;
  logic [PW-1:0]     grant_idx;
  logic              any_grant;
  logic [NUM_FU-1:0] accept;

  rr_arbiter #(.N(NUM_FU), .PW(PW)) u_rr_arbiter (
    .req       (buf_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // A granted buffer drains this edge, so it can take a new result at once.
  assign fu_ready = flush ? '0 : (~buf_valid | grant);
  assign accept   = fu_valid & fu_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_valid <= '0;
      buf_tag   <= '0;
      buf_value <= '0;
      rr_ptr    <= '0;
      cdb_data  <= '0;
    end else if (flush) begin
      buf_valid <= '0;
      rr_ptr    <= '0;
      cdb_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (accept[i]) begin
          buf_valid[i] <= 1'b1;
          buf_tag[i]   <= fu_rob_tag[i];
          buf_value[i] <= fu_value[i];
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
      if (any_grant) begin
        cdb_data.valid   <= 1'b1;
        cdb_data.rob_tag <= buf_tag[grant_idx];
        cdb_data.value   <= buf_value[grant_idx];
        rr_ptr           <= PW'(wrap_next(int'(grant_idx), NUM_FU));
      end else begin
        cdb_data <= '0;
      end
    end
  end

  always_comb begin
    buf_occupancy = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      buf_occupancy = buf_occupancy + OW'(buf_valid[i]);
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single result, full backlog,
// single-port streaming, pointer wrap ordering and flush.
module tb_cdb_arbiter;
  import sys_defs::*;

  logic                                clock;
  logic                                reset;
  logic                                flush;
  logic [3:0]                          fu_valid;
  logic [3:0][`ROB_TAG_LEN-1:0]        fu_rob_tag;
  logic [3:0][`XLEN-1:0]               fu_value;
  logic [3:0]                          fu_ready;
  CDB_DATA                             cdb_data;
  logic [2:0]                          buf_occupancy;

  int checks;
  int errors;

  cdb_arbiter #(.NUM_FU(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .fu_valid      (fu_valid),
    .fu_rob_tag    (fu_rob_tag),
    .fu_value      (fu_value),
    .fu_ready      (fu_ready),
    .cdb_data      (cdb_data),
    .buf_occupancy (buf_occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkCdb(input string tag, input logic v, input logic [`ROB_TAG_LEN-1:0] t,
                          input logic [`XLEN-1:0] val);
    checkOutput({tag, ".valid"}, 64'(cdb_data.valid), 64'(v));
    if (v) begin
      checkOutput({tag, ".tag"}, 64'(cdb_data.rob_tag), 64'(t));
      checkOutput({tag, ".value"}, 64'(cdb_data.value), 64'(val));
    end
  endtask

  task automatic applyStimulus(input int p, input logic v, input logic [`ROB_TAG_LEN-1:0] t,
                               input logic [`XLEN-1:0] val);
    fu_valid[p]   = v;
    fu_rob_tag[p] = t;
    fu_value[p]   = val;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clearInputs();
    flush      = 1'b0;
    fu_valid   = '0;
    fu_rob_tag = '0;
    fu_value   = '0;
  endtask

  task automatic doReset();
    clearInputs();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
  endtask

  logic [`ROB_TAG_LEN-1:0] exp3 [6];
  int cnt [4];
  logic [3:0] rdy;

  initial begin
    checks = 0;
    errors = 0;
    exp3   = '{5'd0, 5'd4, 5'd8, 5'd12, 5'd1, 5'd5};
    clearInputs();
    reset = 1'b0;
    #12;
    checkOutput("por_cdb_valid", 64'(cdb_data.valid), 64'd0);
    checkOutput("por_occupancy", 64'(buf_occupancy), 64'd0);
    reset = 1'b1;
    #1;
    checkOutput("por_ready", 64'(fu_ready), 64'hf);
    tick();

    // Test 1: async reset with all buffers full and a live broadcast.
    for (int p = 0; p < 4; p++) applyStimulus(p, 1'b1, 5'(p + 1), 32'h100 + 32'(p));
    tick();
    clearInputs();
    checkOutput("t1_occ_full", 64'(buf_occupancy), 64'd4);
    tick();
    checkCdb("t1_pre", 1'b1, 5'd1, 32'h100);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("t1_rst_valid", 64'(cdb_data.valid), 64'd0);
    checkOutput("t1_rst_occ", 64'(buf_occupancy), 64'd0);
    reset = 1'b1;
    #1;
    checkOutput("t1_ready", 64'(fu_ready), 64'hf);
    tick();

    // Test 2: single result from port 2.
    doReset();
    applyStimulus(2, 1'b1, 5'd3, 32'hDEADBEEF);
    #1;
    checkOutput("t2_ready2", 64'(fu_ready[2]), 64'd1);
    tick();
    applyStimulus(2, 1'b0, 5'd0, 32'h0);
    checkCdb("t2_c1", 1'b0, 5'd0, 32'h0);
    checkOutput("t2_occ1", 64'(buf_occupancy), 64'd1);
    tick();
    checkCdb("t2_c2", 1'b1, 5'd3, 32'hDEADBEEF);
    checkOutput("t2_occ0", 64'(buf_occupancy), 64'd0);
    tick();
    checkCdb("t2_c3", 1'b0, 5'd0, 32'h0);

    // Test 3: all ports backlogged, grants rotate 0,1,2,3,0,1.
    doReset();
    for (int p = 0; p < 4; p++) begin
      cnt[p] = 0;
      applyStimulus(p, 1'b1, 5'(p * 4), 32'hA000_0000 + 32'(p * 4));
    end
    #1;
    for (int c = 0; c < 7; c++) begin
      checkOutput("t3_ready", 64'(fu_ready), (c == 0) ? 64'hf : 64'(4'b0001 << ((c - 1) % 4)));
      rdy = fu_ready;
      tick();
      for (int p = 0; p < 4; p++) begin
        if (rdy[p]) begin
          cnt[p]++;
          applyStimulus(p, 1'b1, 5'(p * 4 + cnt[p]), 32'hA000_0000 + 32'(p * 4 + cnt[p]));
        end
      end
      if (c == 0) checkCdb("t3_cdb", 1'b0, 5'd0, 32'h0);
      else checkCdb("t3_cdb", 1'b1, exp3[c-1], 32'hA000_0000 + 32'(exp3[c-1]));
      #1;
    end

    // Test 4: port 1 streams back-to-back results at full rate.
    doReset();
    for (int c = 0; c < 6; c++) begin
      if (c < 4) applyStimulus(1, 1'b1, 5'(c), 32'h1000 + 32'(c));
      else applyStimulus(1, 1'b0, 5'd0, 32'h0);
      #1;
      if (c < 4) checkOutput("t4_ready1", 64'(fu_ready[1]), 64'd1);
      tick();
      if (c >= 1 && c <= 4) checkCdb("t4_cdb", 1'b1, 5'(c - 1), 32'h1000 + 32'(c - 1));
      else checkCdb("t4_cdb", 1'b0, 5'd0, 32'h0);
    end

    // Test 5: pointer at 1, ports 0 and 3 buffered.
    doReset();
    applyStimulus(0, 1'b1, 5'd7, 32'h50);
    tick();
    applyStimulus(0, 1'b0, 5'd0, 32'h0);
    tick();
    checkCdb("t5_first", 1'b1, 5'd7, 32'h50);
    applyStimulus(0, 1'b1, 5'd10, 32'h5A);
    applyStimulus(3, 1'b1, 5'd11, 32'h5B);
    #1;
    checkOutput("t5_ready0_a", 64'(fu_ready[0]), 64'd1);
    checkOutput("t5_ready3_a", 64'(fu_ready[3]), 64'd1);
    tick();
    checkCdb("t5_c3", 1'b0, 5'd0, 32'h0);
    checkOutput("t5_occ2", 64'(buf_occupancy), 64'd2);
    applyStimulus(3, 1'b0, 5'd0, 32'h0);
    applyStimulus(0, 1'b1, 5'd12, 32'h5C);
    #1;
    checkOutput("t5_ready0_b", 64'(fu_ready[0]), 64'd0);
    checkOutput("t5_ready3_b", 64'(fu_ready[3]), 64'd1);
    tick();
    checkCdb("t5_port3", 1'b1, 5'd11, 32'h5B);
    #1;
    checkOutput("t5_ready0_c", 64'(fu_ready[0]), 64'd1);
    tick();
    checkCdb("t5_port0", 1'b1, 5'd10, 32'h5A);
    checkOutput("t5_occ1", 64'(buf_occupancy), 64'd1);
    applyStimulus(0, 1'b0, 5'd0, 32'h0);
    tick();
    checkCdb("t5_port0_2nd", 1'b1, 5'd12, 32'h5C);
    tick();
    checkCdb("t5_idle", 1'b0, 5'd0, 32'h0);

    // Test 6: flush with three buffers full and port 1 presenting.
    doReset();
    for (int p = 0; p < 4; p++) applyStimulus(p, 1'b1, 5'(16 + p), 32'h300 + 32'(p));
    tick();
    clearInputs();
    tick();
    checkCdb("t6_pre", 1'b1, 5'd16, 32'h300);
    checkOutput("t6_occ3", 64'(buf_occupancy), 64'd3);
    applyStimulus(1, 1'b1, 5'd9, 32'h99);
    flush = 1'b1;
    #1;
    checkOutput("t6_ready_flush", 64'(fu_ready), 64'h0);
    tick();
    flush = 1'b0;
    applyStimulus(1, 1'b0, 5'd0, 32'h0);
    checkCdb("t6_after", 1'b0, 5'd0, 32'h0);
    checkOutput("t6_occ0", 64'(buf_occupancy), 64'd0);
    tick();
    checkCdb("t6_quiet1", 1'b0, 5'd0, 32'h0);
    applyStimulus(0, 1'b1, 5'd20, 32'h20);
    applyStimulus(3, 1'b1, 5'd21, 32'h21);
    tick();
    checkCdb("t6_quiet2", 1'b0, 5'd0, 32'h0);
    checkOutput("t6_occ2", 64'(buf_occupancy), 64'd2);
    clearInputs();
    tick();
    checkCdb("t6_ptr0_first", 1'b1, 5'd20, 32'h20);
    tick();
    checkCdb("t6_ptr0_second", 1'b1, 5'd21, 32'h21);
    tick();
    checkCdb("t6_idle", 1'b0, 5'd0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Arbitrates the single common data bus (CDB) between NUM_FU functional-unit result ports and drives the registered CDB_DATA consumed by the ROB and reservation stations. Each port has a one-entry result buffer, so an FU can hand off its result and move on. Buffered results are granted round-robin, at most one per cycle. Sits between the FU array and the ROB `cdb_data` input.

Parameters:
NUM_FU, 4, number of FU result ports (>=2; power of two not required)

Ports:
clock  in  1  system clock, posedge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous squash of all buffered/in-flight results
fu_valid  in  [NUM_FU]  port i presents a result this cycle
fu_rob_tag  in  [NUM_FU][`ROB_TAG_LEN]  ROB tag of the result
fu_value  in  [NUM_FU][`XLEN]  result value (store address for stores)
fu_ready  out  [NUM_FU]  port i's result is accepted at the next posedge
cdb_data  out  CDB_DATA  registered broadcast {valid, rob_tag, value}
buf_occupancy  out  [$clog2(NUM_FU+1)]  count of full port buffers (debug/perf)

Behaviour:
- Reset (reset==0, async): all buffers empty; rr_ptr=0; cdb_data={0,0,0}; fu_ready all 1 once reset is released (combinational from empty buffers); buf_occupancy=0.
- Buffer i state: buf_valid[i], buf_tag[i], buf_value[i].
- fu_ready[i] = !flush && (!buf_valid[i] || grant[i]). Transfer on fu_valid[i] && fu_ready[i]: buffer loads at the posedge. FU must hold valid/tag/value stable until ready.
- Arbitration is combinational, over buf_valid only. Search order is rr_ptr, rr_ptr+1, ... mod NUM_FU. The first valid entry gets grant (one-hot or zero). A port's incoming result is never granted in its accept cycle.
- Posedge with grant k: cdb_data <= {1, buf_tag[k], buf_value[k]}; buf_valid[k] cleared unless reloaded the same cycle; rr_ptr <= (k+1) mod NUM_FU.
- Posedge with no grant: cdb_data <= {0,0,0}; rr_ptr holds.
- cdb_data.valid is high for exactly one cycle per granted result.
- Latency: result presented in cycle t with fu_ready=1 appears on cdb_data in cycle t+2 at the earliest. Worst case, with all ports backlogged, is t+1+NUM_FU.
- Throughput: one broadcast per cycle. A single port with continuous results sustains 1/cycle, because grant and reload happen in the same cycle.
- Simultaneous grant and reload on the same port: the buffer takes the new result and the old result goes on the CDB. No loss, no duplicate.
- Starvation freedom: a buffered result is granted within NUM_FU cycles.
- flush (sync, priority over everything except reset): at the posedge all buf_valid are cleared, cdb_data <= {0,0,0}, rr_ptr <= 0. fu_ready is 0 during the flush cycle, so nothing is accepted.
- A reset assertion mid-operation discards buffered results immediately (async). No partial CDB output is permitted.
- buf_occupancy = popcount(buf_valid), registered state view.
- Tag/value are not checked. The arbiter never reorders results within one port.

Decomposition:
- CDB_DATA struct, `ROB_TAG_LEN and `XLEN stay in the shared sys_defs package/header. The struct is not redefined here.
- One sub-module, rr_arbiter #(N): inputs req[N] and ptr; outputs one-hot grant[N], grant_idx, and any_grant. Purely combinational. The pointer register stays in cdb_arbiter.

Test Plan:
1. Assert reset low with all 4 buffers full and cdb_data valid → cdb_data.valid=0, buf_occupancy=0 immediately; fu_ready=4'b1111 after release.
2. Port 2 presents tag 3, value 0xDEADBEEF in cycle 0 only → cdb_data {1,3,0xDEADBEEF} in cycle 2 only; valid=0 in cycles 1 and 3.
3. All 4 ports hold fu_valid continuously with distinct tags → CDB grant order 0,1,2,3,0,1, one per cycle; each port's fu_ready pulses once every 4 cycles.
4. Port 1 alone streams tags 0,1,2,3 on consecutive cycles → fu_ready[1] stays 1; CDB shows tags 0,1,2,3 in cycles 2..5.
5. Ports 0 and 3 are buffered with rr_ptr=1 → port 3 is granted first, then port 0. A second port-0 result sees fu_ready[0]=0 until the cycle port 0 is granted.
6. flush asserted with 3 buffers full and port 1 presenting → fu_ready=0 that cycle; next cycle cdb_data.valid=0, buf_occupancy=0, rr_ptr=0; the port-1 result is not broadcast.
